// File: rtl/sub_accum.sv
// ---------------------------------------------------------------------------
// sub_accum
//   Sequential saturating subtractor. On an accepted start the minuend A is
//   loaded into the accumulator, then N subtrahends are taken from the B
//   stream (valid/ready handshake). Each one is subtracted with two's
//   complement saturation. The final value is published on Y with a
//   one-cycle done pulse. sat reports whether any step of that operation
//   saturated.
//
//   State table
//   IDLE | waiting for start; b_ready=0, busy=0
//   RUN  | consuming subtrahends; b_ready=1, busy=1
//   DONE | result visible on Y/sat, done=1 for this cycle; busy=1
//
// Ports
//   clk      : single clock, rising edge
//   reset    : synchronous, active-high
//   start    : one-cycle operation request, sampled only in IDLE
//   A        : signed minuend, captured on the accepted start
//   B        : signed subtrahend stream, qualified by b_valid
//   b_valid  : B holds a valid subtrahend
//   b_ready  : block accepts B this cycle
//   Y        : signed saturated result, held until the next done
//   done     : one-cycle pulse, Y and sat updated
//   busy     : high in RUN and DONE
//   sat      : saturation flag of the last completed operation
// ---------------------------------------------------------------------------
module sub_accum #(
    parameter int Width = 16,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [Width-1:0] Y,
    output logic             done,
    output logic             busy,
    output logic             sat
);

    localparam int CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0]  LastCnt = CntW'(N - 1);
    localparam logic [Width-1:0] MaxPos  = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] MinNeg  = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [Width-1:0]  acc;
    logic [CntW-1:0]   cnt;
    logic              sat_int;

    logic [Width-1:0]  raw;
    logic              ovf;
    logic              unf;
    logic [Width-1:0]  step_res;
    logic              step_sat;

    // One saturating subtraction step. Overflow and underflow can only occur
    // when the operands have opposite signs and the wrapped result takes the
    // sign of the subtrahend.
    always_comb begin
        raw      = acc - B;
        ovf      = ~acc[Width-1] &  B[Width-1] &  raw[Width-1];
        unf      =  acc[Width-1] & ~B[Width-1] & ~raw[Width-1];
        step_res = raw;
        step_sat = 1'b0;
        if (ovf) begin
            step_res = MaxPos;
            step_sat = 1'b1;
        end else if (unf) begin
            step_res = MinNeg;
            step_sat = 1'b1;
        end
    end

    // Outputs are registered and move together with the state, so b_ready
    // and busy always match the state table above. Y/sat/done are loaded on
    // the final transfer edge, which is the edge entering DONE; they become
    // visible exactly during the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            sat_int <= 1'b0;
            Y       <= '0;
            sat     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            b_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc     <= A;
                        cnt     <= '0;
                        sat_int <= 1'b0;
                        state   <= RUN;
                        busy    <= 1'b1;
                        b_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (b_valid) begin
                        acc     <= step_res;
                        cnt     <= cnt + 1'b1;
                        sat_int <= sat_int | step_sat;
                        if (cnt == LastCnt) begin
                            state   <= DONE;
                            b_ready <= 1'b0;
                            Y       <= step_res;
                            sat     <= sat_int | step_sat;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    b_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_accum.sv
module tb_sub_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] Y;
    logic        done;
    logic        busy;
    logic        sat;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int done_cnt = 0;

    int exp_y[$];
    int exp_s[$];
    int exp_lat[$];

    sub_accum #(.Width(16), .N(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .Y       (Y),
        .done    (done),
        .busy    (busy),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            int ey, es, el;
            done_cnt++;
            if (exp_y.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                ey = exp_y.pop_front();
                es = exp_s.pop_front();
                el = exp_lat.pop_front();
                check("Y", $signed(Y), ey);
                check("sat", {31'd0, sat}, es);
                check("busy_in_done", {31'd0, busy}, 1);
                if (el >= 0) check("latency", cyc - start_cyc, el);
            end
        end
    end

    function automatic int model_sub(input int a, input int b, inout int s);
        int r;
        r = a - b;
        if (r > 32767) begin
            r = 32767;
            s = 1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1;
        end
        return r;
    endfunction

    task automatic do_op(input int a, input int b0, input int b1, input int b2,
                         input int b3, input logic [7:0] vpat, input int vlen,
                         input bit extra_start, input bit start_in_done);
        int bs[4];
        int acc, s, idx, k, d0;
        logic [31:0] bw;
        bit xfer;
        bs  = '{b0, b1, b2, b3};
        acc = a;
        s   = 0;
        for (int i = 0; i < 4; i++) acc = model_sub(acc, bs[i], s);
        exp_y.push_back(acc);
        exp_s.push_back(s);
        exp_lat.push_back((vlen == 0) ? 5 : -1);
        d0 = done_cnt;

        start     = 1'b1;
        A         = a[15:0];
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("b_ready_run", {31'd0, b_ready}, 1);
        idx = 0;
        k   = 0;
        while (idx < 4 && k < 40) begin
            b_valid = (k < vlen) ? vpat[k] : 1'b1;
            bw      = bs[idx];
            B       = bw[15:0];
            start   = extra_start && (k == 2);
            xfer    = b_valid && b_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            k++;
        end
        b_valid = 1'b0;
        start   = 1'b0;
        check("transfers", idx, 4);
        if (start_in_done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_ignored", {31'd0, busy}, 0);
        end
        for (int t = 0; t < 10 && done_cnt == d0; t++) @(posedge clk);
        #1;
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=1 expected=0");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        reset   = 1'b1;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_Y", $signed(Y), 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_b_ready", {31'd0, b_ready}, 0);
        check("rst_sat", {31'd0, sat}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(100, 10, 20, 30, 40, 8'h00, 0, 1'b0, 1'b0);
        do_op(28672, -28672, 0, 0, 0, 8'h00, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("y_hold", $signed(Y), 32767);
        check("sat_hold", {31'd0, sat}, 1);
        do_op(-32768, 1, -1, 0, 0, 8'h00, 0, 1'b0, 1'b1);
        // accepted in the IDLE cycle right after the ignored DONE-cycle start
        do_op(0, -32768, 0, 0, 0, 8'h00, 0, 1'b0, 1'b0);
        do_op(5, 1, 1, 1, 1, 8'b0101_1001, 7, 1'b1, 1'b0);
        d0 = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("extra_start_ignored_done", done_cnt - d0, 0);
        check("extra_start_ignored_busy", {31'd0, busy}, 0);

        // Reset interrupting RUN after two transfers
        start = 1'b1;
        A     = 16'd50;
        @(posedge clk); #1;
        start   = 1'b0;
        b_valid = 1'b1;
        B       = 16'd3;
        repeat (2) @(posedge clk);
        #1;
        d0      = done_cnt;
        reset   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        start   = 1'b0;
        b_valid = 1'b0;
        check("mid_rst_Y", $signed(Y), 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_b_ready", {31'd0, b_ready}, 0);
        check("mid_rst_sat", {31'd0, sat}, 0);
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        do_op(7, 1, 1, 1, 1, 8'h00, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_y.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_accum.md
SUB_ACCUM -- requirements
Module: sub_accum

Interface
REQ-001 SHALL have parameter Width, default 16, meaning operand/result bit width (two's complement signed).
REQ-002 SHALL have parameter N, default 4, meaning number of subtrahends consumed per operation (N >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port A  input  Width  signed minuend, captured on the accepted start.
REQ-007 SHALL have port B  input  Width  signed subtrahend stream, qualified by b_valid.
REQ-008 SHALL have port b_valid  input  1  B holds a valid subtrahend.
REQ-009 SHALL have port b_ready  output  1  block accepts B this cycle.
REQ-010 SHALL have port Y  output  Width  signed saturated result, held until the next done.
REQ-011 SHALL have port done  output  1  one-cycle pulse; Y valid and updated.
REQ-012 SHALL have port busy  output  1  high in RUN and DONE.
REQ-013 SHALL have port sat  output  1  sticky saturation flag for the last completed operation, updated with done.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: b_ready=0, busy=0; start=1 -> acc<=A, cnt<=0, sat_int<=0, next RUN.
REQ-016 RUN: b_ready=1, busy=1; a transfer occurs only when b_valid=1 and b_ready=1.
REQ-017 On each transfer, acc SHALL become satsub(acc,B), cnt SHALL increment, and sat_int SHALL set if that step saturated.
REQ-018 A transfer with cnt==N-1 SHALL move to DONE; b_valid=0 cycles SHALL leave acc, cnt and sat_int unchanged (no timeout).
REQ-019 DONE: b_ready=0, busy=1; Y<=acc, sat<=sat_int, done=1 for exactly one cycle, next IDLE.
REQ-020 satsub: raw = acc-B computed modulo 2^Width; overflow if acc[Width-1]=0, B[Width-1]=1 and raw[Width-1]=1 -> result 0111...1.
REQ-021 satsub: underflow if acc[Width-1]=1, B[Width-1]=0 and raw[Width-1]=0 -> result 1000...0; otherwise result = raw.
REQ-022 Subsequent steps SHALL continue from the saturated value; there SHALL be no wider internal accumulator.
REQ-023 start SHALL be ignored while busy=1; start in the DONE cycle SHALL be ignored, and start in the next IDLE cycle SHALL be accepted.
REQ-024 With b_valid held high, latency from accepted start to done SHALL be N+1 cycles.
REQ-025 Y and sat SHALL change only in the DONE cycle or on reset.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE and set Y=0, done=0, busy=0, b_ready=0, sat=0, acc=0, cnt=0, sat_int=0.
REQ-027 reset SHALL take priority over start and over any transfer in the same cycle; an operation interrupted by reset SHALL produce no done.

Verification
REQ-028 A=100, B=10,20,30,40 with b_valid held high -> done 5 cycles after start, Y=0, sat=0.
REQ-029 A=28672, B=-28672,0,0,0 -> Y=32767, sat=1.
REQ-030 A=-32768, B=1,-1,0,0 -> first step underflows to -32768, then -32767, Y=-32767, sat=1.
REQ-031 A=0, B=-32768,0,0,0 -> Y=32767 (overflow edge), sat=1.
REQ-032 b_valid toggled 1,0,0,1,1,0,1 with A=5, B=1 each -> exactly 4 transfers, Y=1, a second start pulsed during RUN is ignored.
REQ-033 reset asserted mid-RUN after 2 transfers -> no done pulse, Y=0, busy=0; a subsequent start with A=7, B=1,1,1,1 -> Y=3.
